// File: rtl/acc_arb.sv
// Two-requester round-robin burst accumulator: grants one requester at a time
// and sums its len samples into a registered accumulator with a sticky carry flag.
module acc_arb #(
    parameter int W_X = 10,
    parameter int W_A = 16
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic [1:0]     req,
    input  logic [7:0]     len0,
    input  logic [7:0]     len1,
    input  logic [W_X-1:0] x0,
    input  logic [W_X-1:0] x1,
    input  logic           vld0,
    input  logic           vld1,
    output logic           rdy0,
    output logic           rdy1,
    output logic [1:0]     gnt,
    output logic [W_A-1:0] sum,
    output logic           done,
    output logic           done_id,
    output logic           ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [W_A-1:0] sum_q, sum_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           id_q, id_d;   // index of the requester currently granted
    logic           ptr_q, ptr_d; // requester that wins a tie on the next grant

    logic           win;
    logic [7:0]     len_win;
    logic [W_X-1:0] x_sel;
    logic           vld_sel;
    logic           hs;
    logic [W_A:0]   add;

    always_comb begin
        win     = (req == 2'b11) ? ptr_q : req[1];
        len_win = win ? len1 : len0;
        x_sel   = id_q ? x1 : x0;
        vld_sel = id_q ? vld1 : vld0;
        hs      = (state_q == ACC) && vld_sel;
        add     = {1'b0, sum_q} + (W_A + 1)'(x_sel);
    end

    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    id_d    = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = len_win;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_win == 8'd0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (hs) begin
                    sum_d = add[W_A-1:0];
                    ovf_d = ovf_q | add[W_A];
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                ptr_d   = ~id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; the async reset clears all of them, including mid-burst.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rdy0    = (state_q == ACC) && !id_q;
    assign rdy1    = (state_q == ACC) && id_q;
    assign gnt     = gnt_q;
    assign sum     = sum_q;
    assign ovf     = ovf_q;
    assign done    = (state_q == DONE);
    assign done_id = (state_q == DONE) && id_q;

endmodule

// File: tb/tb_acc_arb.sv
// Randomized scoreboard bench for acc_arb: bursts are predicted from totals of the
// issued samples and compared by a monitor whenever done pulses.
module tb_acc_arb;

    localparam int W_X = 10;
    localparam int W_A = 16;
    localparam int MOD = 1 << W_A;

    typedef int iq_t[$];
    typedef struct {
        bit id;
        int sum;
        bit ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_b;
    logic [1:0]     req;
    logic [7:0]     len0, len1;
    logic [W_X-1:0] x_a[2];
    logic           vld_a[2];
    logic           rdy0, rdy1, done, done_id, ovf;
    logic [1:0]     gnt;
    logic [W_A-1:0] sum;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   prio = 1'b0;

    acc_arb #(.W_X(W_X), .W_A(W_A)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .x0     (x_a[0]),
        .x1     (x_a[1]),
        .vld0   (vld_a[0]),
        .vld1   (vld_a[1]),
        .rdy0   (rdy0),
        .rdy1   (rdy1),
        .gnt    (gnt),
        .sum    (sum),
        .done   (done),
        .done_id(done_id),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic iq_t gen(input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(int'($urandom_range((1 << W_X) - 1)));
        return q;
    endfunction

    function automatic logic rdy_of(input bit i);
        return i ? rdy1 : rdy0;
    endfunction

    // Monitor: every done pulse retires the oldest predicted burst.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b === 1'b1) begin
                check("rdy0_without_gnt", rdy0 & ~gnt[0], 0);
                check("rdy1_without_gnt", rdy1 & ~gnt[1], 0);
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_id", done_id, e.id);
                        check("final_sum", sum, e.sum);
                        check("final_ovf", ovf, e.ovf);
                    end
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle; returns at the first idle negedge.
    task automatic run_burst(input logic [1:0] r, input logic [7:0] l0, input logic [7:0] l1,
                             input iq_t s0, input iq_t s1, input int vld_pct, input int gap);
        bit   w;
        int   ow, len_w, total, idx, cyc, partial, stall_left;
        iq_t  s;
        exp_t e;
        w     = (r == 2'b11) ? prio : (r == 2'b10);
        ow    = w ? 0 : 1;
        len_w = w ? int'(l1) : int'(l0);
        s     = w ? s1 : s0;
        total = 0;
        for (int i = 0; i < len_w; i++) total += s[i];
        e.id  = w;
        e.sum = total % MOD;
        e.ovf = (total >= MOD);
        sb.push_back(e);

        req = r; len0 = l0; len1 = l1;
        @(negedge clk);
        check("gnt_at_grant", gnt, w ? 2'b10 : 2'b01);
        check("sum_cleared", sum, 0);
        check("ovf_cleared", ovf, 0);
        req  = 2'($urandom);
        len0 = 8'($urandom);
        len1 = 8'($urandom);

        if (len_w == 0) begin
            check("zero_len_done", done, 1);
            check("zero_len_rdy", rdy_of(w), 0);
        end else begin
            check("rdy_at_grant", rdy_of(w), 1);
            idx = 0; cyc = 0; partial = 0; stall_left = gap;
            while (idx < len_w) begin
                vld_a[ow] = 1'($urandom);
                x_a[ow]   = W_X'($urandom);
                if (idx == 1 && stall_left > 0) begin
                    stall_left--;
                    vld_a[w] = 1'b0;
                    check("stall_sum", sum, partial);
                    check("stall_rdy", rdy_of(w), 1);
                end else begin
                    vld_a[w] = ($urandom_range(99) < vld_pct);
                    x_a[w]   = vld_a[w] ? W_X'(s[idx]) : W_X'($urandom);
                end
                @(posedge clk);
                if (vld_a[w]) begin
                    partial = (partial + s[idx]) % MOD;
                    idx++;
                end
                @(negedge clk);
                cyc++;
                if (cyc > 5000) begin
                    check("handshake_timeout", cyc, 0);
                    break;
                end
            end
            vld_a[0] = 1'b0; vld_a[1] = 1'b0;
            check("done_after_last_hs", done, 1);
            check("rdy_drop_in_done", rdy_of(w), 0);
            check("gnt_held_in_done", gnt, w ? 2'b10 : 2'b01);
        end
        req  = 2'b00;
        prio = ~w;
        @(negedge clk);
        check("gnt_idle", gnt, 2'b00);
        check("done_one_cycle", done, 0);
        check("sum_hold", sum, e.sum);
        check("ovf_hold", ovf, e.ovf);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        iq_t ov;
        rst_b = 1'b0; req = 2'b00; len0 = 8'd0; len1 = 8'd0;
        x_a[0] = '0; x_a[1] = '0; vld_a[0] = 1'b0; vld_a[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_gnt", gnt, 0);
        check("reset_sum", sum, 0);
        check("reset_rdy", {rdy1, rdy0}, 0);
        check("reset_done", {done, done_id, ovf}, 0);
        rst_b = 1'b1;

        // Contention from reset, then single burst, stall, zero length, overflow.
        run_burst(2'b11, 8'd2, 8'd2, gen(2), gen(2), 100, 0);
        run_burst(2'b11, 8'd2, 8'd2, gen(2), gen(2), 100, 0);
        run_burst(2'b11, 8'd2, 8'd2, gen(2), gen(2), 100, 0);
        run_burst(2'b01, 8'd3, 8'd0, '{1, 4, 7}, gen(0), 100, 0);
        run_burst(2'b10, 8'd0, 8'd2, gen(0), '{10, 20}, 100, 5);
        run_burst(2'b01, 8'd0, 8'd5, gen(0), gen(5), 100, 0);
        for (int i = 0; i < 100; i++) ov.push_back(1023);
        run_burst(2'b01, 8'd100, 8'd0, ov, gen(0), 100, 0);
        run_burst(2'b01, 8'd1, 8'd0, '{0}, gen(0), 100, 0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] a, b;
            if ($urandom_range(4) == 0) @(negedge clk);
            a = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
            b = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
            run_burst(2'($urandom_range(1, 3)), a, b, gen(a), gen(b), $urandom_range(40, 100), 0);
        end

        // Reset in the middle of a burst after two of five samples.
        req = 2'b01; len0 = 8'd5;
        @(negedge clk);
        check("mid_gnt", gnt, 2'b01);
        req = 2'b00; vld_a[0] = 1'b1; x_a[0] = 10'd3;
        @(posedge clk);
        @(negedge clk);
        x_a[0] = 10'd4;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_sum", sum, 7);
        vld_a[0] = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_rdy", {rdy1, rdy0}, 0);
        check("async_sum", sum, 0);
        check("async_flags", {done, done_id, ovf}, 0);
        prio = 1'b0;
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        check("gnt_in_reset", gnt, 0);
        rst_b = 1'b1;
        run_burst(2'b11, 8'd2, 8'd3, gen(2), gen(3), 80, 0);
        run_burst(2'b11, 8'd2, 8'd3, gen(2), gen(3), 80, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_arb.md
ACC_ARB -- requirements
Module: acc_arb

Interface
REQ-001 Parameter W_X, default 10, width of each sample input.
REQ-002 Parameter W_A, default 16, accumulator and sum width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester burst request, bit i = requester i.
REQ-006 len0, len1  input  8  burst length in samples; sampled only at grant.
REQ-007 x0, x1  input  W_X  sample data per requester, unsigned.
REQ-008 vld0, vld1  input  1  sample valid per requester.
REQ-009 rdy0, rdy1  output  1  sample ready per requester.
REQ-010 gnt  output  2  one-hot grant, registered; 00 when idle.
REQ-011 sum  output  W_A  accumulator value, registered.
REQ-012 done  output  1  one-cycle pulse at burst completion.
REQ-013 done_id  output  1  index of the requester whose burst completed; valid while done=1.
REQ-014 ovf  output  1  sticky carry-out flag for the current burst.

Function
REQ-015 The FSM SHALL have states IDLE, ACC and DONE.
REQ-016 IDLE: if req != 00, SHALL select the winner, set gnt one-hot, latch the winner's len into a down-counter, clear sum and ovf, and go to ACC (len != 0) or DONE (len == 0), all on the same edge.
REQ-017 Arbitration SHALL be round-robin: the requester not served last has priority; after reset requester 0 has priority.
REQ-018 ACC: rdy of the granted requester SHALL be 1 and the other rdy SHALL be 0; both rdy SHALL be 0 in IDLE and DONE.
REQ-019 ACC: on vld&rdy, sum SHALL update to sum + zero-extended x (mod 2^W_A) and the counter SHALL decrement; no change without the handshake (stall any number of cycles).
REQ-020 Carry out of the MSB during any add SHALL set ovf; ovf holds until the next grant or reset.
REQ-021 The handshake that brings the counter to 0 SHALL move the FSM to DONE; rdy SHALL be 0 from the next cycle on.
REQ-022 DONE: done=1 and done_id=granted index for exactly one cycle, gnt held; the next state SHALL be IDLE with gnt=00 and the priority pointer moved to the other requester.
REQ-023 sum and ovf SHALL hold their final values after DONE until the next grant clears them.
REQ-024 Latency: req seen in IDLE -> gnt and rdy visible the next cycle; last handshake -> done the next cycle; minimum spacing between consecutive grants is 2 cycles (DONE, IDLE).
REQ-025 Changes on req, len or the non-granted x/vld during ACC or DONE SHALL be ignored; dropping req mid-burst SHALL NOT abort the burst.
REQ-026 len=0 SHALL produce a burst with no handshakes: done one cycle after the grant, with sum=0 and ovf=0.

Reset
REQ-027 rst_b=0 SHALL, asynchronously, force state IDLE, gnt=00, rdy0=rdy1=0, sum=0, ovf=0, done=0, done_id=0, counter=0 and priority pointer to requester 0, including in the middle of a burst.
REQ-028 After rst_b is released, the first grant SHALL occur no earlier than the first rising edge with rst_b=1.

Verification
REQ-029 Single burst: req=01, len0=3, x0=1,4,7 with vld0 continuous -> gnt=01, sum=12, ovf=0, done pulse with done_id=0 one cycle after the third handshake.
REQ-030 Contention: req=11 held from reset, len0=len1=2 -> gnt sequence 01, 00, 10, 00, 01; done_id alternates 0,1,0.
REQ-031 Stall: len1=2, vld1 low for 5 cycles between two samples x1=10,20 -> sum stays at 10 while stalled, final sum=30, rdy1 held 1 throughout the stall.
REQ-032 Zero length: req=01, len0=0 -> done one cycle after gnt=01, sum=0, rdy0 never asserted.
REQ-033 Overflow: len0=100, x0=1023 on every sample -> final sum=36764, ovf=1; the next grant clears sum and ovf to 0.
REQ-034 Reset mid-burst: rst_b low after 2 of 5 samples -> all outputs 0 immediately; after release, req=11 grants requester 0 first.
